// File: rtl/zigbee_pkg.sv
// Shared constants and types for the ZigBee symbol/word datapath.
// Used by symbol_packer and its nibble-lane write decoder.
package zigbee_pkg;

    localparam int SYM_W         = 4;
    localparam int SYMS_PER_WORD = 8;
    localparam int WORD_W        = 32;
    localparam int CNT_W         = 4;
    localparam int POS_W         = 3;

    typedef logic [SYM_W-1:0]  sym_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  symcnt_t;

endpackage

// File: rtl/sym_lane_wr.sv
// Combinational 1-to-8 nibble-lane write decoder: merges one symbol into the accumulator.
// Lane order is LSB-first unless SYMBOL_PACKER_MSB_FIRST_EN is defined.
module sym_lane_wr
    import zigbee_pkg::*;
(
    input  word_t            acc_i,
    input  sym_t             sym_i,
    input  logic [POS_W-1:0] pos_i,
    output word_t            word_o
);

    logic [POS_W-1:0] lane_s;
    logic [4:0]       shamt_s;

    // Map symbol position to a nibble lane and overwrite that lane in the accumulator.
    always_comb begin
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
        lane_s = POS_W'(SYMS_PER_WORD - 1) - pos_i;
`else
        lane_s = pos_i;
`endif
        shamt_s = {lane_s, 2'b00};
        word_o  = (acc_i & ~(WORD_W'(4'hF) << shamt_s)) | (WORD_W'(sym_i) << shamt_s);
    end

endmodule

// File: rtl/symbol_packer.sv
// Packs 4-bit ZigBee symbols into 32-bit words with early termination on a last flag.
// Optional macro SYMBOL_PACKER_MSB_FIRST_EN places the first symbol in the top nibble.
module symbol_packer
    import zigbee_pkg::*;
(
    input  logic         inClk,
    input  logic         inRst,
    input  logic [3:0]   inSym,
    input  logic         inSymValid,
    input  logic         inSymLast,
    output logic         outSymReady,
    output logic [31:0]  outWord,
    output logic [3:0]   outWordCnt,
    output logic         outWordLast,
    output logic         outWordValid,
    input  logic         inWordReady
);

    word_t   acc_q,   acc_d;
    symcnt_t cnt_q,   cnt_d;
    word_t   word_q,  word_d;
    symcnt_t wcnt_q,  wcnt_d;
    logic    wlast_q, wlast_d;
    logic    wvld_q,  wvld_d;

    logic    accept_s;
    logic    complete_s;
    word_t   merged_s;

    sym_lane_wr u_lane_wr (
        .acc_i  (acc_q),
        .sym_i  (inSym),
        .pos_i  (cnt_q[POS_W-1:0]),
        .word_o (merged_s)
    );

    // Handshake: room exists when no word is pending or the pending one leaves this cycle.
    always_comb begin
        outSymReady = !inRst && (!wvld_q || inWordReady);
        accept_s    = inSymValid && outSymReady;
        complete_s  = accept_s && ((cnt_q == symcnt_t'(SYMS_PER_WORD - 1)) || inSymLast);
    end

    // Next-state for accumulator, symbol counter and output word register.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wcnt_d  = wcnt_q;
        wlast_d = wlast_q;
        wvld_d  = wvld_q;
        if (complete_s) begin
            word_d  = merged_s;
            wcnt_d  = cnt_q + 4'd1;
            wlast_d = inSymLast;
            wvld_d  = 1'b1;
            acc_d   = 32'h0000_0000;
            cnt_d   = 4'd0;
        end else begin
            if (accept_s) begin
                acc_d = merged_s;
                cnt_d = cnt_q + 4'd1;
            end else begin
                acc_d = acc_q;
            end
            if (wvld_q && inWordReady) begin
                wvld_d = 1'b0;
            end else begin
                wvld_d = wvld_q;
            end
        end
    end

    // State registers with synchronous reset that discards any partial or pending word.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            acc_q   <= 32'h0000_0000;
            cnt_q   <= 4'd0;
            word_q  <= 32'h0000_0000;
            wcnt_q  <= 4'd0;
            wlast_q <= 1'b0;
            wvld_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
            wlast_q <= wlast_d;
            wvld_q  <= wvld_d;
        end
    end

    assign outWord      = word_q;
    assign outWordCnt   = wcnt_q;
    assign outWordLast  = wlast_q;
    assign outWordValid = wvld_q;

endmodule

// File: tb/tb_symbol_packer.sv
// Self-checking bench for symbol_packer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of symbol framing.
module tb_symbol_packer;

    logic        clk = 1'b0;
    logic        inRst = 1'b1;
    logic [3:0]  inSym = 4'h0;
    logic        inSymValid = 1'b0;
    logic        inSymLast = 1'b0;
    logic        inWordReady = 1'b0;
    logic        outSymReady;
    logic [31:0] outWord;
    logic [3:0]  outWordCnt;
    logic        outWordLast;
    logic        outWordValid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  cnt;
        logic        last;
    } wexp_t;

    logic [3:0] frame[$];
    wexp_t      pend[$];
    bit         zero_q = 1'b1;

    symbol_packer dut (
        .inClk        (clk),
        .inRst        (inRst),
        .inSym        (inSym),
        .inSymValid   (inSymValid),
        .inSymLast    (inSymLast),
        .outSymReady  (outSymReady),
        .outWord      (outWord),
        .outWordCnt   (outWordCnt),
        .outWordLast  (outWordLast),
        .outWordValid (outWordValid),
        .inWordReady  (inWordReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic wexp_t pack_frame(input bit last);
        wexp_t r;
        r.word = 32'h0;
        for (int k = 0; k < frame.size(); k++) begin
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
            r.word = r.word + (32'(frame[k]) << (4 * (7 - k)));
`else
            r.word = r.word + (32'(frame[k]) << (4 * k));
`endif
        end
        r.cnt  = 4'(frame.size());
        r.last = last;
        return r;
    endfunction

    // One clock cycle: drive, check against the model, advance the model, pass the edge.
    task automatic cycle(input bit v, input logic [3:0] s, input bit l, input bit wr, input bit rst);
        bit exp_valid;
        bit exp_ready;
        @(negedge clk);
        inRst = rst; inSymValid = v; inSym = s; inSymLast = l; inWordReady = wr;
        #1;
        exp_valid = (pend.size() != 0);
        exp_ready = !rst && (!exp_valid || wr);
        chk("ready", 32'(outSymReady), 32'(exp_ready));
        chk("valid", 32'(outWordValid), 32'(exp_valid));
        if (exp_valid) begin
            chk("word", outWord, pend[0].word);
            chk("cnt",  32'(outWordCnt), 32'(pend[0].cnt));
            chk("last", 32'(outWordLast), 32'(pend[0].last));
        end else if (zero_q) begin
            chk("word0", outWord, 32'h0);
            chk("cnt0",  32'(outWordCnt), 32'h0);
            chk("last0", 32'(outWordLast), 32'h0);
        end
        if (rst) begin
            pend.delete();
            frame.delete();
            zero_q = 1'b1;
        end else begin
            if (exp_valid && wr) void'(pend.pop_front());
            if (v && exp_ready) begin
                frame.push_back(s);
                if (frame.size() == 8 || l) begin
                    pend.push_back(pack_frame(l));
                    frame.delete();
                    zero_q = 1'b0;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        // Initial reset, outputs observed directly
        inRst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word", outWord, 32'h0);
        chk("rst_valid", 32'(outWordValid), 32'h0);
        chk("rst_ready", 32'(outSymReady), 32'h0);

        // 8 back-to-back symbols 1..8
        for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
        #1;
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
        chk("w12345678", outWord, 32'h12345678);
`else
        chk("w87654321", outWord, 32'h87654321);
`endif
        chk("w8cnt", 32'(outWordCnt), 32'h8);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Short frame A,B,C with last
        cycle(1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
        #1;
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
        chk("wABC", outWord, 32'hABC00000);
`else
        chk("wABC", outWord, 32'h00000CBA);
`endif
        chk("wABClast", 32'(outWordLast), 32'h1);

        // MSB/LSB two-symbol frame with last
        cycle(1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'h2, 1'b1, 1'b1, 1'b0);
        #1;
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
        chk("w12", outWord, 32'h12000000);
`else
        chk("w12", outWord, 32'h00000021);
`endif
        chk("w12cnt", 32'(outWordCnt), 32'h2);

        // Lone last symbol, then a full word held by backpressure
        cycle(1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 3), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 4), 1'b0, 1'b1, 1'b0);

        // Last flag without valid is ignored
        cycle(1'b0, 4'hF, 1'b1, 1'b1, 1'b0);

        // Reset mid-word after 5 accepts
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'hD, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'h5, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);

        // 16 continuous symbols 0..F
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
        #1;
`ifdef SYMBOL_PACKER_MSB_FIRST_EN
        chk("w89ABCDEF", outWord, 32'h89ABCDEF);
`else
        chk("wFEDCBA98", outWord, 32'hFEDCBA98);
`endif
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 8) == 0,
                  ($urandom % 3) != 0, ($urandom % 100) == 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
